// File: rtl/pq_arbiter_if.sv
// rtl/pq_arbiter_if.sv - requester command / dequeue response bus shared by N requesters
//
// Signals:
//   req_valid  [N]    per-requester command valid
//   req_op     [N]    per-requester op, 0=ENQ 1=DEQ
//   req_value  [N*W]  per-requester enqueue value, requester i at [i*W +: W]
//   req_ready  [N]    one-hot accept from the arbiter
//   resp_valid        dequeue response valid
//   resp_id    [IW]   requester that issued the dequeue
//   resp_value [W]    dequeued value (0 when resp_empty)
//   resp_empty        dequeue found the queue empty
//   resp_ready        response accepted by the requester side
// Modports: master = requester side, slave = arbiter side.
interface pq_arbiter_if #(
    parameter int N = 2,
    parameter int W = 32
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_value;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_value;
    logic           resp_empty;
    logic           resp_ready;

    modport master (
        output req_valid, req_op, req_value, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_value, resp_empty
    );

    modport slave (
        input  req_valid, req_op, req_value, resp_ready,
        output req_ready, resp_valid, resp_id, resp_value, resp_empty
    );
endinterface

// File: rtl/pq_arbiter.sv
// rtl/pq_arbiter.sv - round-robin arbiter sharing one pipelined max-priority queue between N requesters
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (shared with the pq)
//   bus (slave)           requester commands and dequeue responses, see pq_arbiter_if
//   count [L]             current occupancy 0..CAP
//   full, empty           count==CAP, count==0
//   err                   sticky: pq returned no data on a dequeue we tracked as nonempty
//   pq_enq_valid/value    enqueue command to the pq
//   pq_enq_ready          pq can accept the enqueue
//   pq_deq_req            one-cycle dequeue pulse to the pq
//   pq_deq_value/valid    dequeue result from the pq, one cycle after pq_deq_req
module pq_arbiter #(
    parameter int N = 2,
    parameter int L = 3,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pq_arbiter_if.slave    bus,
    output logic [L-1:0]   count,
    output logic           full,
    output logic           empty,
    output logic           err,
    output logic           pq_enq_valid,
    output logic [W-1:0]   pq_enq_value,
    input  logic           pq_enq_ready,
    output logic           pq_deq_req,
    input  logic [W-1:0]   pq_deq_value,
    input  logic           pq_deq_valid
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [L-1:0] CAP = L'((1 << L) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DEQ_WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic          cur_op;      // 0=ENQ, 1=DEQ for the command in flight

    logic [N-1:0]  eligible;
    logic [N-1:0]  grant;
    logic [IW-1:0] gid;
    logic          found;
    logic          handshake;
    logic [IW-1:0] next_ptr;

    assign full  = (count == CAP);
    assign empty = (count == '0);

    // An ENQ blocked by a full queue is simply not eligible, so it never
    // holds up a DEQ (or anything else) from another requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = bus.req_valid[i] & (bus.req_op[i] | (count < CAP));
        end
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        int idx;
        grant = '0;
        gid   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                gid        = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    assign bus.req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign handshake     = (state == IDLE) && found;
    assign next_ptr      = (gid == IW'(N - 1)) ? '0 : gid + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cur_op         <= 1'b0;
            count          <= '0;
            err            <= 1'b0;
            pq_enq_valid   <= 1'b0;
            pq_enq_value   <= '0;
            pq_deq_req     <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_value <= '0;
            bus.resp_empty <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        rr_ptr      <= next_ptr;
                        cur_op      <= bus.req_op[gid];
                        bus.resp_id <= gid;
                        if (!bus.req_op[gid]) begin
                            pq_enq_valid <= 1'b1;
                            pq_enq_value <= bus.req_value[int'(gid)*W +: W];
                            state        <= ISSUE;
                        end else if (count != '0) begin
                            pq_deq_req <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            // Nothing tracked in the pq: answer empty without touching it.
                            bus.resp_valid <= 1'b1;
                            bus.resp_empty <= 1'b1;
                            bus.resp_value <= '0;
                            state          <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (!cur_op) begin
                        // Returning to IDLE for a cycle paces issue to the pq token rate.
                        if (pq_enq_ready) begin
                            pq_enq_valid <= 1'b0;
                            count        <= count + L'(1);
                            state        <= IDLE;
                        end
                    end else begin
                        pq_deq_req <= 1'b0;
                        state      <= DEQ_WAIT;
                    end
                end
                DEQ_WAIT: begin
                    bus.resp_valid <= 1'b1;
                    if (pq_deq_valid) begin
                        bus.resp_value <= pq_deq_value;
                        bus.resp_empty <= 1'b0;
                        count          <= count - L'(1);
                    end else begin
                        // Occupancy tracking disagrees with the pq; resynchronise to empty.
                        bus.resp_value <= '0;
                        bus.resp_empty <= 1'b1;
                        count          <= '0;
                        err            <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pq_arbiter.sv
// tb/tb_pq_arbiter.sv - directed self-checking bench for pq_arbiter with a behavioural max-pq model
module tb_pq_arbiter;
    localparam int N = 2;
    localparam int L = 3;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [L-1:0]  count;
    logic          full, empty, err;
    logic          pq_enq_valid;
    logic [W-1:0]  pq_enq_value;
    logic          pq_enq_ready;
    logic          pq_deq_req;
    logic [W-1:0]  pq_deq_value;
    logic          pq_deq_valid;
    logic          pq_drop;

    int checks = 0;
    int errors = 0;
    int deq_pulses = 0;

    int exp_rdy[8] = '{1, 0, 2, 0, 1, 0, 2, 0};
    int exp_env[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    pq_arbiter_if #(.N(N), .W(W)) bus ();

    pq_arbiter #(.N(N), .L(L), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .err          (err),
        .pq_enq_valid (pq_enq_valid),
        .pq_enq_value (pq_enq_value),
        .pq_enq_ready (pq_enq_ready),
        .pq_deq_req   (pq_deq_req),
        .pq_deq_value (pq_deq_value),
        .pq_deq_valid (pq_deq_valid)
    );

    always #5 clk = ~clk;

    // Behavioural max-priority queue: result one cycle after deq_req.
    logic [W-1:0] mem [8];
    logic [7:0]   occ;
    int           max_i, free_i;
    logic         max_found, free_found;

    always_comb begin
        max_i = 0; max_found = 1'b0; free_i = 0; free_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (occ[i] && (!max_found || mem[i] > mem[max_i])) begin
                max_i = i; max_found = 1'b1;
            end
            if (!occ[i] && !free_found) begin
                free_i = i; free_found = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ          <= '0;
            pq_deq_valid <= 1'b0;
            pq_deq_value <= '0;
        end else begin
            pq_deq_valid <= 1'b0;
            if (pq_enq_valid && pq_enq_ready && free_found) begin
                mem[free_i] <= pq_enq_value;
                occ[free_i] <= 1'b1;
            end
            if (pq_deq_req) begin
                pq_deq_valid <= max_found && !pq_drop;
                pq_deq_value <= max_found ? mem[max_i] : '0;
                if (max_found) occ[max_i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (pq_deq_req) deq_pulses++;
        if (rst_n) begin
            assert (!(pq_enq_valid && pq_deq_req)) else begin
                errors++;
                $error("FAIL enq_deq_overlap: observed 1 expected 0");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input int id, input logic op, input logic [W-1:0] val);
        int t;
        bus.req_valid[id] = 1'b1;
        bus.req_op[id] = op;
        bus.req_value[id*W +: W] = val;
        #1;
        t = 0;
        while (!bus.req_ready[id] && t < 20) begin
            @(negedge clk); #1; t++;
        end
        chk("grant", bus.req_ready[id], 1'b1);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic enq(input int id, input logic [W-1:0] val);
        do_req(id, 1'b0, val);
    endtask

    task automatic deq(input int id, input logic [W-1:0] ev, input logic ee, input int elat, input int hold);
        int lat;
        do_req(id, 1'b1, '0);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        chk("resp_lat", lat, elat);
        chk("resp_id", bus.resp_id, id);
        chk("resp_value", bus.resp_value, ev);
        chk("resp_empty", bus.resp_empty, ee);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", bus.resp_valid, 1'b1);
            chk("hold_value", bus.resp_value, ev);
            chk("hold_id", bus.resp_id, id);
            chk("hold_ready", bus.req_ready, 2'b00);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("resp_done", bus.resp_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int pulses0;
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_value = '0;
        bus.resp_ready = 1'b0;
        pq_enq_ready = 1'b1;
        pq_drop = 1'b0;

        // Reset state, with requests pending to show req_ready is forced low
        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_pq_enq", pq_enq_valid, 1'b0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk); #1;

        // 1: ENQ x3 then DEQ x3 from requester 0
        enq(0, 32'h4);
        enq(0, 32'h44);
        enq(0, 32'h444);
        @(negedge clk); #1;
        chk("t1_count3", count, 3);
        deq(0, 32'h444, 1'b0, 3, 0);
        deq(0, 32'h44, 1'b0, 3, 0);
        deq(0, 32'h4, 1'b0, 3, 0);
        chk("t1_count0", count, 0);
        chk("t1_empty", empty, 1'b1);

        // 2: DEQ on empty after reset: 1-cycle latency, pq untouched
        do_reset();
        pulses0 = deq_pulses;
        deq(1, 32'h0, 1'b1, 1, 0);
        chk("t2_no_deq_req", deq_pulses, pulses0);

        // 3: fill to CAP, then ENQ blocked while DEQ from the other requester proceeds
        do_reset();
        for (int i = 1; i <= 7; i++) enq(0, W'(i));
        @(negedge clk); #1;
        chk("t3_full", full, 1'b1);
        chk("t3_count7", count, 7);
        bus.req_op = 2'b10;
        bus.req_value = {32'h0, 32'h9};
        bus.req_valid = 2'b11;
        #1;
        chk("t3_ready", bus.req_ready, 2'b10);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        #1;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            chk("t3_r0_blocked", bus.req_ready[0], 1'b0);
            @(negedge clk); #1; lat++;
        end
        chk("t3_lat", lat, 3);
        chk("t3_resp_id", bus.resp_id, 1);
        chk("t3_resp_value", bus.resp_value, 32'h7);
        chk("t3_count6", count, 6);
        chk("t3_resp_ready0", bus.req_ready, 2'b00);
        bus.req_valid = 2'b00;
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        bus.resp_ready = 1'b0;

        // 4: both requesters ENQ continuously: alternating grants, pq issue every 2nd cycle
        do_reset();
        bus.req_op = 2'b00;
        bus.req_value = {32'h20, 32'h10};
        bus.req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t4_grant", bus.req_ready, exp_rdy[c]);
            chk("t4_enq_valid", pq_enq_valid, exp_env[c]);
            if (c == 7) bus.req_valid = 2'b00;
            @(negedge clk);
        end
        #1;
        chk("t4_count4", count, 4);
        deq(1, 32'h20, 1'b0, 3, 0);

        // 5: response back-pressure for 5 cycles with another request pending
        bus.req_op[1] = 1'b0;
        bus.req_value[W +: W] = 32'h30;
        bus.req_valid[1] = 1'b1;
        deq(0, 32'h20, 1'b0, 3, 5);
        bus.req_valid[1] = 1'b0;
        chk("t5_count", count, 2);

        // 6: reset while waiting for the pq result
        do_req(0, 1'b1, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_resp_valid", bus.resp_valid, 1'b0);
        chk("t6_deq_req", pq_deq_req, 1'b0);
        chk("t6_enq_valid", pq_enq_valid, 1'b0);
        chk("t6_ready", bus.req_ready, 2'b00);
        chk("t6_resp_value", bus.resp_value, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        deq(1, 32'h0, 1'b1, 1, 0);

        // pq fails to return data on a tracked-nonempty dequeue
        pq_drop = 1'b1;
        enq(0, 32'h55);
        @(negedge clk); #1;
        chk("err_pre", err, 1'b0);
        deq(0, 32'h0, 1'b1, 3, 0);
        chk("err_set", err, 1'b1);
        chk("err_count", count, 0);
        pq_drop = 1'b0;
        enq(1, 32'h66);
        @(negedge clk); #1;
        chk("err_sticky", err, 1'b1);
        chk("err_count1", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
